// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises icache/dcache line traffic onto one
// 64-bit burst memory port, one outstanding transaction at a time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_dfp_*             icache line read port (addr/read -> rdata/resp)
//   d_dfp_*             dcache line read/writeback port
//   bmem_*              burst memory: command/write beats out,
//                       ready in, tagged read beats (raddr/rdata/rvalid) in
//
// Build option:
//   CACHE_ARB_RR_EN     round-robin icache/dcache arbitration
//                       (default: fixed dcache priority)
module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_dfp_addr,
    input  logic              i_dfp_read,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,
    input  logic [31:0]       d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [31:0] OFF_MASK = 32'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_BURST,
        RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              own_d_q;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wbuf_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    logic        d_req;
    logic        any_req;
    logic        pick_d;
    logic        pick_wr;
    logic        beat_hit;
    logic        last_cnt;
    logic [31:0] req_addr;

    // Arbitration, evaluated only while IDLE.
    always_comb begin
        d_req   = d_dfp_read | d_dfp_write;
        any_req = d_req | i_dfp_read;
`ifdef CACHE_ARB_RR_EN
        // own_d_q still names the last served owner while idle;
        // that owner yields when both sides are requesting.
        pick_d  = d_req & ~(i_dfp_read & own_d_q);
`else
        pick_d  = d_req;
`endif
        // Write beats read inside the dcache (both high is illegal).
        pick_wr  = pick_d & d_dfp_write;
        req_addr = (pick_d ? d_dfp_addr : i_dfp_addr) & ~OFF_MASK;
    end

    assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);
    assign last_cnt = (cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        i_dfp_resp = 1'b0;
        d_dfp_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = pick_wr ? WR_BURST : RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (beat_hit && last_cnt) begin
                    state_d = RESP;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wbuf_q[int'(cnt_q)*BEAT_W +: BEAT_W];
                if (bmem_ready && last_cnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                i_dfp_resp = ~own_d_q;
                d_dfp_resp = own_d_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            own_d_q   <= 1'b1;
            addr_q    <= '0;
            wbuf_q    <= '0;
            line_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        own_d_q <= pick_d;
                        addr_q  <= req_addr;
                        cnt_q   <= '0;
                        if (pick_wr) begin
                            wbuf_q <= d_dfp_wdata;
                        end
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        cnt_q <= '0;
                    end
                end
                RD_WAIT: begin
                    if (beat_hit) begin
                        line_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= bmem_rdata;
                        cnt_q <= cnt_q + 1'b1;
                        // Final beat goes straight into the owner's
                        // fill register so it is valid during RESP.
                        if (last_cnt) begin
                            if (own_d_q) begin
                                d_rdata_q <= {bmem_rdata,
                                    line_q[LINE_W-BEAT_W-1:0]};
                            end else begin
                                i_rdata_q <= {bmem_rdata,
                                    line_q[LINE_W-BEAT_W-1:0]};
                            end
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign i_dfp_rdata = i_rdata_q;
    assign d_dfp_rdata = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter with a
// behavioural burst memory, requester agents and a response monitor.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_dfp_addr;
    logic         i_dfp_read;
    logic [255:0] i_dfp_rdata;
    logic         i_dfp_resp;
    logic [31:0]  d_dfp_addr;
    logic         d_dfp_read;
    logic         d_dfp_write;
    logic [255:0] d_dfp_wdata;
    logic [255:0] d_dfp_rdata;
    logic         d_dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    cache_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // ---------------- memory contents ----------------
    logic [63:0] mem [logic [31:0]];
    logic [63:0] ref_mem [logic [31:0]];

    function automatic logic [63:0] init_beat(input logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, ~a};
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_beat(a);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  b;
        b = {a[31:5], 5'b0};
        for (int k = 0; k < 4; k++) begin
            if (ref_mem.exists(b + 32'(8*k)))
                l[64*k +: 64] = ref_mem[b + 32'(8*k)];
            else
                l[64*k +: 64] = init_beat(b + 32'(8*k));
        end
        return l;
    endfunction

    // ---------------- burst memory model ----------------
    typedef struct {
        int          t;
        logic [31:0] a;
        logic [63:0] d;
    } beat_t;

    beat_t       bq[$];
    int          lat = 3;
    bit          lat_rand = 0;
    bit          rdy_rand = 0;
    bit          spur_en = 0;
    bit          stall_b2 = 0;
    int          wacc = 0;
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    int          beats_out = 0;
    int          last_acc_cyc = 0;
    logic [31:0] cmd_log[$];
    logic [63:0] wlog[$];
    logic [63:0] wplog[$];

    initial begin
        bit r;
        int lq;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        forever begin
            @(negedge clk);
            r = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_b2 && bmem_write && wacc == 2) begin
                r = 1'b0;
                stall_b2 = 0;
            end
            bmem_ready = r;
            if (bmem_read) begin
                rd_cycles++;
                if (r) begin
                    cmd_log.push_back(bmem_addr);
                    lq = lat_rand ? int'($urandom_range(1, 4)) : lat;
                    for (int k = 0; k < 4; k++)
                        bq.push_back('{cyc + lq + k, bmem_addr,
                                       mem_rd(bmem_addr + 32'(8*k))});
                end
            end
            if (bmem_write) begin
                wr_cycles++;
                wplog.push_back(bmem_wdata);
                if (r) begin
                    mem[bmem_addr + 32'(8*wacc)] = bmem_wdata;
                    wlog.push_back(bmem_wdata);
                    last_acc_cyc = cyc;
                    wacc = (wacc == 3) ? 0 : wacc + 1;
                end
            end
            if (bq.size() > 0 && bq[0].t <= cyc) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = bq[0].a;
                bmem_rdata  = bq[0].d;
                void'(bq.pop_front());
                beats_out++;
            end else if (spur_en) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'hDEAD_BEE0;
                bmem_rdata  = {$urandom(), $urandom()};
            end else begin
                bmem_rvalid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit           wr;
        logic [255:0] line;
    } exp_t;

    exp_t         i_exp[$];
    exp_t         d_exp[$];
    bit           order_log[$];
    logic [255:0] last_d_fill = '0;
    int           d_resp_cnt = 0;

    initial begin
        bit   prev_i;
        bit   prev_d;
        exp_t e;
        prev_i = 0;
        prev_d = 0;
        forever begin
            @(negedge clk);
            if (i_dfp_resp || d_dfp_resp)
                check("resp_excl", 256'(i_dfp_resp & d_dfp_resp), '0);
            if (i_dfp_resp) begin
                check("i_resp_pulse", 256'(prev_i), '0);
                check("i_outstanding", 256'(i_exp.size() > 0), 256'(1));
                if (i_exp.size() > 0) begin
                    e = i_exp.pop_front();
                    check("i_rdata", i_dfp_rdata, e.line);
                end
                order_log.push_back(1'b0);
            end
            if (d_dfp_resp) begin
                d_resp_cnt++;
                check("d_resp_pulse", 256'(prev_d), '0);
                check("d_outstanding", 256'(d_exp.size() > 0), 256'(1));
                if (d_exp.size() > 0) begin
                    e = d_exp.pop_front();
                    if (e.wr) begin
                        check("d_rdata_kept", d_dfp_rdata, last_d_fill);
                    end else begin
                        check("d_rdata", d_dfp_rdata, e.line);
                        last_d_fill = e.line;
                    end
                end
                order_log.push_back(1'b1);
            end
            prev_i = i_dfp_resp;
            prev_d = d_dfp_resp;
        end
    end

    // ---------------- requester agents ----------------
    task automatic wait_resp(input bit use_d, input string nm,
                             output int rc);
        int n = 0;
        rc = -1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (use_d ? d_dfp_resp : i_dfp_resp) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no resp within 400 cycles", nm);
        end
    endtask

    task automatic i_op(input logic [31:0] a, input bit keep,
                        output int rc);
        i_dfp_addr = a;
        i_dfp_read = 1'b1;
        i_exp.push_back('{1'b0, ref_line(a)});
        wait_resp(1'b0, "i_resp_wait", rc);
        if (!keep) i_dfp_read = 1'b0;
    endtask

    task automatic d_op(input logic [31:0] a, input bit wr,
                        input logic [255:0] line, input bit keep,
                        output int rc);
        logic [31:0] b;
        d_dfp_addr  = a;
        d_dfp_read  = !wr;
        d_dfp_write = wr;
        d_dfp_wdata = line;
        if (wr) begin
            b = {a[31:5], 5'b0};
            for (int k = 0; k < 4; k++)
                ref_mem[b + 32'(8*k)] = line[64*k +: 64];
            d_exp.push_back('{1'b1, '0});
        end else begin
            d_exp.push_back('{1'b0, ref_line(a)});
        end
        wait_resp(1'b1, "d_resp_wait", rc);
        if (!keep) begin
            d_dfp_read  = 1'b0;
            d_dfp_write = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int           rc;
        int           rc1;
        int           rc2;
        int           t0;
        int           base;
        int           n;
        int           c0;
        logic [63:0]  bw [4];
        logic [255:0] wline;
        logic [1:0]   got;

        rst         = 1'b1;
        i_dfp_addr  = '0;
        i_dfp_read  = 1'b0;
        d_dfp_addr  = '0;
        d_dfp_read  = 1'b0;
        d_dfp_write = 1'b0;
        d_dfp_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_bmem", 256'({bmem_addr, bmem_read, bmem_write,
                                  bmem_wdata}), '0);
        check("reset_rdata", i_dfp_rdata | d_dfp_rdata, '0);
        check("reset_resp", 256'({i_dfp_resp, d_dfp_resp}), '0);
        rst = 1'b0;
        @(negedge clk);

        // icache read, L=3, zero-wait ready
        for (int k = 0; k < 4; k++) begin
            mem[32'h1220 + 32'(8*k)] = 64'h1111_1111_1111_1111 * (k + 1);
            ref_mem[32'h1220 + 32'(8*k)] =
                64'h1111_1111_1111_1111 * (k + 1);
        end
        lat = 3;
        rd_cycles = 0;
        cmd_log.delete();
        t0 = cyc;
        i_op(32'h0000_1234, 1'b0, rc);
        check("t1_resp_cycle", 256'(rc - t0), 256'd8);
        check("t1_cmd_count", 256'(cmd_log.size()), 256'd1);
        check("t1_cmd_addr",
              256'(cmd_log.size() > 0 ? cmd_log[0] : 32'h0),
              256'h1220);
        check("t1_read_cycles", 256'(rd_cycles), 256'd1);
        repeat (2) @(negedge clk);
        check("t1_rdata_hold", i_dfp_rdata,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // dcache writeback with one stall on beat 2
        for (int k = 0; k < 4; k++) begin
            bw[k] = {32'hB000_0000 + 32'(k), 32'hC0FF_EE00 + 32'(k)};
            wline[64*k +: 64] = bw[k];
        end
        stall_b2 = 1;
        wacc = 0;
        wr_cycles = 0;
        wlog.delete();
        wplog.delete();
        d_op(32'h8000_0040, 1'b1, wline, 1'b0, rc);
        check("t2_accepted", wlog.size() == 4 ?
              {wlog[3], wlog[2], wlog[1], wlog[0]} : '0, wline);
        check("t2_presented_n", 256'(wplog.size()), 256'd5);
        check("t2_beat2_held", wplog.size() == 5 ?
              256'({wplog[3], wplog[2]}) : '0, 256'({bw[2], bw[2]}));
        check("t2_write_cycles", 256'(wr_cycles), 256'd5);
        check("t2_resp_cycle", 256'(rc - last_acc_cyc), 256'd1);

        // simultaneous icache and dcache read
        order_log.delete();
        fork
            i_op(32'h0000_0400, 1'b0, rc1);
            d_op(32'h0000_0500, 1'b0, '0, 1'b0, rc2);
        join
        got = (order_log.size() == 2) ?
              {order_log[0], order_log[1]} : 2'b11;
`ifdef CACHE_ARB_RR_EN
        check("t3_order_i_first", 256'(got), 256'(2'b01));
`else
        check("t3_order_d_first", 256'(got), 256'(2'b10));
`endif

        // spurious beats with a foreign tag during RD_WAIT
        spur_en = 1;
        lat = 5;
        d_op(32'h0000_0100, 1'b0, '0, 1'b0, rc);
        i_op(32'h0000_0104, 1'b0, rc);
        spur_en = 0;

        // reset after two captured read beats
        lat = 2;
        base = beats_out;
        d_dfp_addr = 32'h0000_0200;
        d_dfp_read = 1'b1;
        n = 0;
        while (beats_out - base < 2 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t5_two_beats", 256'(beats_out - base >= 2), 256'(1));
        rst = 1'b1;
        last_d_fill = '0;
        @(posedge clk);
        @(negedge clk);
        check("t5_bmem_zero", 256'({bmem_addr, bmem_read, bmem_write,
                                    bmem_wdata}), '0);
        check("t5_rdata_zero", i_dfp_rdata | d_dfp_rdata, '0);
        check("t5_resp_zero", 256'({i_dfp_resp, d_dfp_resp}), '0);
        rst = 1'b0;
        d_dfp_read = 1'b0;
        @(negedge clk);
        d_op(32'h0000_0300, 1'b0, '0, 1'b0, rc);

        // back-to-back dcache reads
        c0 = d_resp_cnt;
        d_op(32'h8000_0040, 1'b0, '0, 1'b1, rc);
        d_op(32'h8000_0060, 1'b0, '0, 1'b0, rc);
        repeat (4) @(negedge clk);
        check("t6_resp_count", 256'(d_resp_cnt - c0), 256'd2);

        // randomized mixed traffic
        lat_rand = 1;
        rdy_rand = 1;
        spur_en  = 1;
        fork
            begin
                int rci;
                for (int i = 0; i < 25; i++) begin
                    i_op(32'($urandom_range(0, 16'h3FFF)),
                         1'b0, rci);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                int          rcd;
                bit          wr;
                bit          kp;
                logic [31:0] a;
                logic [255:0] l;
                for (int i = 0; i < 25; i++) begin
                    wr = ($urandom_range(0, 2) == 0);
                    if (wr || $urandom_range(0, 1) == 1)
                        a = 32'h8000_0000 |
                            32'($urandom_range(0, 31) << 5) |
                            32'($urandom_range(0, 31));
                    else
                        a = 32'($urandom_range(0, 16'h3FFF));
                    for (int k = 0; k < 8; k++)
                        l[32*k +: 32] = $urandom();
                    kp = (i != 24) && ($urandom_range(0, 3) == 0);
                    d_op(a, wr, l, kp, rcd);
                    if (!kp)
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join
        spur_en = 0;
        repeat (10) @(negedge clk);
        check("i_drained", 256'(i_exp.size()), '0);
        check("d_drained", 256'(d_exp.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
